// File: rtl/cgra_cfg_pkg.sv
// CGRA config controller: register map, bit indices, FSM states.
package cgra_cfg_pkg;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_CFG_ADDR = 8'h08;
   localparam logic [7:0] OFF_CFG_DATA = 8'h0C;
   localparam logic [7:0] OFF_RUN_CYC  = 8'h10;

   localparam int CTRL_START    = 0;
   localparam int CTRL_SOFT_RST = 1;
   localparam int CTRL_IRQ_EN   = 2;

   localparam int ST_BUSY  = 0;
   localparam int ST_DONE  = 1;
   localparam int ST_FULL  = 2;
   localparam int ST_EMPTY = 3;
   localparam int ST_OVF   = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONFIG,
      S_RUN,
      S_DONE
   } state_e;

endpackage

// File: rtl/cgra_cfg_if.sv
// Wishbone slave port bundle for the CGRA config controller.
interface cgra_cfg_if;

   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i,
      output wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
      input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

endinterface

// File: rtl/cgra_cfg_fifo.sv
// Synchronous FIFO holding {cfg address, cfg data} beats.
module cgra_cfg_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign level   = cnt;
   assign rdata   = mem[rp];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) begin
            mem[wp] <= wdata;
            wp      <= wp + 1'b1;
         end
         if (do_pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/cgra_cfg_ctrl.sv
// Wishbone-driven loader: streams FIFO'd config beats into the CGRA,
// runs it for a programmed cycle count, then flags done / IRQ.
module cgra_cfg_ctrl
   import cgra_cfg_pkg::*;
#(
   parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
   parameter int          FIFO_DEPTH         = 8,
   parameter int          CFG_AW             = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   cgra_cfg_if.slave         wb,
   output logic [CFG_AW-1:0] cfg_addr_o,
   output logic [31:0]       cfg_data_o,
   output logic              cfg_valid_o,
   input  logic              cfg_ready_i,
   output logic              cgra_run_o,
   output logic              irq_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = CFG_AW + 32;

   state_e            state, nstate;
   logic [31:0]       cnt, ncnt;
   logic              ack_q;
   logic [31:0]       dat_q, rdata, status;
   logic              irq_en, done, ovf;
   logic [CFG_AW-1:0] cfg_addr_q;
   logic [31:0]       run_cycles;
   logic              hit, acc, wr;
   logic [7:0]        off;
   logic              sel_ctrl, sel_stat, sel_addr, sel_data, sel_run;
   logic              start, soft_rst, push_req, push, pop;
   logic              full, empty;
   logic [LW-1:0]     level;
   logic [FW-1:0]     head;
   logic              unused_sel;

   assign unused_sel = ^wb.wbs_sel_i;

   assign hit = wb.wbs_stb_i & wb.wbs_cyc_i
              & (wb.wbs_adr_i[31:8] == WISHBONE_BASE_ADDR[31:8]);
   assign acc = hit & ~ack_q;
   assign wr  = acc & wb.wbs_we_i;
   assign off = wb.wbs_adr_i[7:0];

   assign sel_ctrl = off == OFF_CTRL;
   assign sel_stat = off == OFF_STATUS;
   assign sel_addr = off == OFF_CFG_ADDR;
   assign sel_data = off == OFF_CFG_DATA;
   assign sel_run  = off == OFF_RUN_CYC;

   // soft reset takes priority over a start carried in the same write
   assign soft_rst = wr & sel_ctrl & wb.wbs_dat_i[CTRL_SOFT_RST];
   assign start    = wr & sel_ctrl & wb.wbs_dat_i[CTRL_START] & ~soft_rst;
   assign push_req = wr & sel_data;
   assign push     = push_req & ~full;

   assign cfg_valid_o = (state == S_CONFIG) & ~empty;
   assign pop         = cfg_valid_o & cfg_ready_i;
   assign cfg_addr_o  = cfg_valid_o ? head[FW-1:32] : '0;
   assign cfg_data_o  = cfg_valid_o ? head[31:0] : '0;
   assign cgra_run_o  = state == S_RUN;
   assign irq_o       = done & irq_en;

   cgra_cfg_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .flush (soft_rst),
      .push  (push),
      .pop   (pop),
      .wdata ({cfg_addr_q, wb.wbs_dat_i}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_comb begin
      status           = '0;
      status[ST_BUSY]  = state != S_IDLE;
      status[ST_DONE]  = done;
      status[ST_FULL]  = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF]   = ovf;
      status[15:8]     = 8'(level);
   end

   always_comb begin
      rdata = '0;
      unique case (1'b1)
         sel_ctrl: rdata[CTRL_IRQ_EN] = irq_en;
         sel_stat: rdata = status;
         sel_addr: rdata = 32'(cfg_addr_q);
         sel_run:  rdata = run_cycles;
         default:  rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= acc;
         dat_q <= acc ? rdata : '0;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         irq_en     <= 1'b0;
         cfg_addr_q <= '0;
         run_cycles <= '0;
         done       <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         if (wr & sel_ctrl) irq_en <= wb.wbs_dat_i[CTRL_IRQ_EN];
         if (wr & sel_addr) cfg_addr_q <= wb.wbs_dat_i[CFG_AW-1:0];
         else if (push)     cfg_addr_q <= cfg_addr_q + 1'b1;
         if (wr & sel_run)  run_cycles <= wb.wbs_dat_i;
         if (wr & sel_stat & wb.wbs_dat_i[ST_DONE]) done <= 1'b0;
         if (state == S_DONE) done <= 1'b1;
         if (wr & sel_stat & wb.wbs_dat_i[ST_OVF]) ovf <= 1'b0;
         if (push_req & full) ovf <= 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
      end
   end

   always_comb begin
      nstate = state;
      ncnt   = cnt;
      unique case (state)
         S_IDLE: if (start) nstate = S_CONFIG;
         // a push landing on an empty FIFO keeps us here so it gets drained
         S_CONFIG: if (empty & ~push) begin
            if (run_cycles == '0) nstate = S_DONE;
            else begin
               nstate = S_RUN;
               ncnt   = run_cycles;
            end
         end
         S_RUN: begin
            ncnt = cnt - 1'b1;
            if (cnt <= 32'd1) nstate = S_DONE;
         end
         S_DONE:  nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
      if (soft_rst) nstate = S_IDLE;
   end

endmodule

// File: tb/tb_cgra_cfg_ctrl.sv
// Scoreboard bench for cgra_cfg_ctrl: WB reads and config beats are
// checked by monitors against queues filled by the stimulus.
module tb_cgra_cfg_ctrl;
   import cgra_cfg_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_valid, cfg_ready, run, irq;

   cgra_cfg_if wb();

   cgra_cfg_ctrl dut (
      .wb_clk_i    (clk),
      .wb_rst_ni   (rst_n),
      .wb          (wb),
      .cfg_addr_o  (cfg_addr),
      .cfg_data_o  (cfg_data),
      .cfg_valid_o (cfg_valid),
      .cfg_ready_i (cfg_ready),
      .cgra_run_o  (run),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] v;
      string       nm;
   } exp_t;

   exp_t        rd_q[$];
   logic [47:0] beat_q[$];
   int          beat_cyc[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          run_cnt = 0;
   exp_t        e;
   logic [47:0] eb;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (run) run_cnt++;

   always @(negedge clk) begin
      if (wb.wbs_ack_o && !wb.wbs_we_i) begin
         checks++;
         if (rd_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got=%h", wb.wbs_dat_o);
         end else begin
            e = rd_q.pop_front();
            if (wb.wbs_dat_o !== e.v) begin
               failures++;
               $display("FAIL %s got=%h exp=%h", e.nm, wb.wbs_dat_o, e.v);
            end
         end
      end
      if (cfg_valid && cfg_ready) begin
         checks++;
         beat_cyc.push_back(cyc);
         if (beat_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected got=%h/%h", cfg_addr, cfg_data);
         end else begin
            eb = beat_q.pop_front();
            if ({cfg_addr, cfg_data} !== eb) begin
               failures++;
               $display("FAIL beat got=%h exp=%h", {cfg_addr, cfg_data}, eb);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic we, input logic [7:0] off,
                       input logic [31:0] d);
      int n;
      @(posedge clk);
      #1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_we_i  = we;
      wb.wbs_adr_i = BASE | {24'h0, off};
      wb.wbs_dat_i = d;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!wb.wbs_ack_o && n < 8);
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      checks++;
      if (!wb.wbs_ack_o) begin
         failures++;
         $display("FAIL ack_timeout got=0 exp=1 off=%h", off);
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      xfer(1'b1, off, d);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] v,
                     input string nm);
      rd_q.push_back('{v, nm});
      xfer(1'b0, off, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   logic [31:0] vals [3];

   initial begin
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_sel_i = 4'hF;
      wb.wbs_adr_i = '0;
      wb.wbs_dat_i = '0;
      cfg_ready    = 1'b0;
      vals[0] = 32'hAAAA_0001;
      vals[1] = 32'hBBBB_0002;
      vals[2] = 32'hCCCC_0003;
      idle(3);
      check("rst_outs", {wb.wbs_ack_o, cfg_valid, run, irq}, 0);
      rst_n = 1'b1;
      rd(OFF_STATUS, 32'h8, "rst_status");
      rd(OFF_CTRL, 32'h0, "rst_ctrl");
      rd(OFF_CFG_ADDR, 32'h0, "rst_cfg_addr");
      wr(8'h40, 32'hFFFF_FFFF);
      rd(8'h40, 32'h0, "unmapped");
      rd(OFF_CFG_DATA, 32'h0, "cfg_data_rd");

      wr(OFF_CFG_ADDR, 32'h10);
      for (int i = 0; i < 3; i++) begin
         wr(OFF_CFG_DATA, vals[i]);
         beat_q.push_back({16'(16'h10 + i), vals[i]});
      end
      rd(OFF_CFG_ADDR, 32'h13, "load_addr");
      rd(OFF_STATUS, 32'h300, "load_level");
      wr(OFF_RUN_CYC, 32'd5);
      rd(OFF_RUN_CYC, 32'd5, "run_cycles_rd");
      cfg_ready = 1'b1;
      run_cnt = 0;
      beat_cyc.delete();
      wr(OFF_CTRL, 32'h1);
      idle(20);
      check("load_run_cnt", run_cnt, 5);
      check("load_beats", beat_cyc.size(), 3);
      if (beat_cyc.size() == 3)
         check("load_consec", beat_cyc[2] - beat_cyc[0], 2);
      rd(OFF_STATUS, 32'hA, "load_done");

      cfg_ready = 1'b0;
      wr(OFF_STATUS, 32'h2);
      wr(OFF_CFG_ADDR, 32'h20);
      for (int i = 0; i < 3; i++) begin
         wr(OFF_CFG_DATA, vals[i] ^ 32'h0F0F_0000);
         beat_q.push_back({16'(16'h20 + i), vals[i] ^ 32'h0F0F_0000});
      end
      wr(OFF_RUN_CYC, 32'd2);
      run_cnt = 0;
      wr(OFF_CTRL, 32'h1);
      check("bp_valid", cfg_valid, 1);
      cfg_ready = 1'b1;
      idle(1);
      cfg_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("bp_hold", {cfg_valid, cfg_addr, cfg_data},
               {1'b1, 16'h21, vals[1] ^ 32'h0F0F_0000});
         idle(1);
      end
      cfg_ready = 1'b1;
      idle(20);
      check("bp_run_cnt", run_cnt, 2);
      rd(OFF_STATUS, 32'hA, "bp_done");

      cfg_ready = 1'b0;
      wr(OFF_STATUS, 32'h2);
      wr(OFF_CFG_ADDR, 32'h100);
      for (int i = 0; i < 9; i++) wr(OFF_CFG_DATA, 32'(i));
      rd(OFF_STATUS, 32'h814, "ovf_status");
      rd(OFF_CFG_ADDR, 32'h108, "ovf_addr");

      wr(OFF_CTRL, 32'h1);
      check("abort_pre_valid", cfg_valid, 1);
      wr(OFF_CTRL, 32'h2);
      check("abort_valid", cfg_valid, 0);
      rd(OFF_STATUS, 32'h18, "abort_status");
      wr(OFF_STATUS, 32'h10);
      rd(OFF_STATUS, 32'h8, "ovf_clear");

      wr(OFF_CTRL, 32'h4);
      rd(OFF_CTRL, 32'h4, "irq_en_rd");
      wr(OFF_RUN_CYC, 32'd0);
      run_cnt = 0;
      wr(OFF_CTRL, 32'h5);
      idle(8);
      check("irq_high", irq, 1);
      check("zero_run_cnt", run_cnt, 0);
      rd(OFF_STATUS, 32'hA, "zero_done");
      wr(OFF_STATUS, 32'h2);
      check("irq_clear", irq, 0);
      rd(OFF_STATUS, 32'h8, "irq_status");

      wr(OFF_RUN_CYC, 32'd50);
      wr(OFF_CTRL, 32'h5);
      idle(5);
      check("pre_rst_run", run, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", {wb.wbs_ack_o, cfg_valid, run, irq}, 0);
      idle(2);
      rst_n = 1'b1;
      rd(OFF_STATUS, 32'h8, "post_rst_status");
      rd(OFF_CTRL, 32'h0, "post_rst_ctrl");
      rd(OFF_RUN_CYC, 32'h0, "post_rst_run_cyc");

      idle(3);
      check("rd_q_empty", rd_q.size(), 0);
      check("beat_q_empty", beat_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
